// File: rtl/reg_bank_arbiter_pkg.sv
// Shared defaults, address-width derivation and one-hot helper for reg_bank_arbiter.
// Optional collision counter is enabled by defining REG_BANK_COLLISION_EN.
package reg_bank_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // A single-entry bank or requester still needs a one-bit index.
  function automatic int aw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [WIDTH_DEF-1:0] entry_t;

  function automatic int onehot_to_idx(input logic [7:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_arbiter
  import reg_bank_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int PW   = aw_of(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    win     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'((int'(ptr) + k) % NREQ);
      if (!w_found && eligible[w_idx]) begin
        win[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign valid = w_found;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NREQ round-robin write requesters with a free read port.
// Define REG_BANK_COLLISION_EN to add the saturating coll_cnt output.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = aw_of(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data
`ifdef REG_BANK_COLLISION_EN
  ,
  output logic [7:0]            coll_cnt
`endif
);

  localparam int PW = aw_of(NREQ);

  logic [WIDTH-1:0] r_bank [DEPTH];
  logic [NREQ-1:0]  r_gnt;
  logic             r_busy;
  logic [PW-1:0]    r_ptr;

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_win;
  logic             w_valid;
  logic [AW-1:0]    w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;
  logic [DEPTH-1:0] w_load;
  logic [WIDTH-1:0] w_bank_d [DEPTH];
  int               w_win_idx;
  logic [PW-1:0]    w_ptr_d;

  // Masking the granted requester stops a still-held req from writing twice.
  assign w_elig = req & ~r_gnt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .eligible (w_elig),
    .ptr      (r_ptr),
    .win      (w_win),
    .valid    (w_valid)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_sel_addr = w_sel_addr | wr_addr[i*AW +: AW];
        w_sel_data = w_sel_data | wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_load[e]   = w_valid && (w_sel_addr == AW'(e));
      w_bank_d[e] = w_load[e] ? w_sel_data : r_bank[e];
    end
  end

  assign w_win_idx = onehot_to_idx(8'(w_win));
  assign w_ptr_d   = (w_win_idx == NREQ - 1) ? '0 : PW'(w_win_idx + 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bank <= '{default: '0};
      r_gnt  <= '0;
      r_busy <= 1'b0;
      r_ptr  <= '0;
    end else begin
      r_bank <= w_bank_d;
      r_gnt  <= w_valid ? w_win : '0;
      r_busy <= w_valid;
      if (w_valid) r_ptr <= w_ptr_d;
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign rd_data = r_bank[rd_addr];

`ifdef REG_BANK_COLLISION_EN
  logic       w_multi;
  logic [7:0] r_coll_cnt;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = (w_elig & (w_elig - 1'b1)) != '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_coll_cnt <= '0;
    end else if (w_multi && r_coll_cnt != 8'hFF) begin
      r_coll_cnt <= r_coll_cnt + 8'd1;
    end
  end

  assign coll_cnt = r_coll_cnt;
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (default NREQ=4, WIDTH=8, DEPTH=4).
`timescale 1ns/1ps
module tb_reg_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic        busy;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
`ifdef REG_BANK_COLLISION_EN
  logic [7:0]  coll_cnt;
`endif

  int n_cmp;
  int n_bad;

  reg_bank_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .gnt     (gnt),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`ifdef REG_BANK_COLLISION_EN
    ,
    .coll_cnt(coll_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req     = '0;
    wr_addr = '0;
    wr_data = '0;
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rd_addr = '0;
    do_reset();
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_bank%0d: got %h expected 00", a, rd_data); end
    end
  endtask

  task automatic test_single();
    req        = 4'b0001;
    wr_addr    = 8'h02;
    wr_data    = 32'h0000_00A5;
    rd_addr    = 2'd2;
    #1;
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL single_nobypass: got %h expected 00", rd_data); end
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", busy); end
    n_cmp++; if (rd_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h expected a5", rd_data); end
    req = 4'b0000;
    tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_gnt_drop: got %b expected 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
    rd_addr = 2'd1;
    #1;
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL single_hold: got %h expected 00", rd_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req     = 4'b1111;
    wr_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    wr_data = 32'h1312_1110;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (gnt !== exp_seq[c]) begin n_bad++; $display("FAIL rr_gnt%0d: got %b expected %b", c, gnt, exp_seq[c]); end
    end
    req = 4'b0000;
    tick();
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      n_cmp++; if (rd_data !== 8'(8'h10 + a)) begin n_bad++; $display("FAIL rr_bank%0d: got %h expected %h", a, rd_data, 8'(8'h10 + a)); end
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    rd_addr = 2'd0;
    req     = 4'b1010;
    wr_addr = 8'h00;
    wr_data = 32'h3300_1100;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL same_first_gnt: got %b expected 0010", gnt); end
    n_cmp++; if (rd_data !== 8'h11) begin n_bad++; $display("FAIL same_first_data: got %h expected 11", rd_data); end
    req = 4'b1000;
    tick();
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL same_second_gnt: got %b expected 1000", gnt); end
    n_cmp++; if (rd_data !== 8'h33) begin n_bad++; $display("FAIL same_second_data: got %h expected 33", rd_data); end
    req = 4'b0000;
    tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL same_idle_gnt: got %b expected 0000", gnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req     = 4'b0001;
    wr_addr = 8'h03;
    wr_data = 32'h0000_00C3;
    tick();
    req     = 4'b0100;
    wr_addr = 8'h10;
    wr_data = 32'h005A_0000;
    rd_addr = 2'd3;
    #1;
    n_cmp++; if (rd_data !== 8'hC3) begin n_bad++; $display("FAIL async_pre_data: got %h expected c3", rd_data); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL async_gnt: got %b expected 0000", gnt); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL async_bank: got %h expected 00", rd_data); end
    @(posedge clk);
    #3 reset = 1'b1;
    rd_addr = 2'd1;
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL async_post_gnt: got %b expected 0100", gnt); end
    n_cmp++; if (rd_data !== 8'h5A) begin n_bad++; $display("FAIL async_post_data: got %h expected 5a", rd_data); end
    req = 4'b0000;
    tick();
  endtask

`ifdef REG_BANK_COLLISION_EN
  task automatic test_collision();
    do_reset();
    n_cmp++; if (coll_cnt !== 8'd0) begin n_bad++; $display("FAIL coll_reset: got %0d expected 0", coll_cnt); end
    req     = 4'b1111;
    wr_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    wr_data = 32'h1312_1110;
    for (int c = 0; c < 3; c++) tick();
    n_cmp++; if (coll_cnt !== 8'd3) begin n_bad++; $display("FAIL coll_count3: got %0d expected 3", coll_cnt); end
    for (int c = 0; c < 297; c++) tick();
    n_cmp++; if (coll_cnt !== 8'd255) begin n_bad++; $display("FAIL coll_saturate: got %0d expected 255", coll_cnt); end
    req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    req     = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    #3 reset = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_same_addr();
    test_async_reset();
`ifdef REG_BANK_COLLISION_EN
    test_collision();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
